// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the KGP-miniRISC instruction sequencer:
// state encoding, the halt opcode and the memory-access opcodes.
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_e;

    localparam logic [5:0]  HALT_OP_DEF  = 6'b111111;
    localparam logic [5:0]  OP_LW        = 6'b100011;
    localparam logic [5:0]  OP_SW        = 6'b101011;
    localparam int unsigned WAIT_MAX_DEF = 15;

    // States in which the sequencer is waiting on a memory acknowledge.
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM);
    endfunction

endpackage

// File: rtl/instr_sequencer_wait_timer.sv
// Memory-wait watchdog shared by FETCH and MEM: counts cycles without an
// acknowledge and flags a timeout on the WAIT_MAX-th such cycle.
module instr_sequencer_wait_timer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    input  logic ack,
    output logic timeout
);

    localparam logic [7:0] LAST_WAIT = 8'(WAIT_MAX - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // NOTE: give every always_comb output a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || ack) begin
            cnt_d = 8'd0;
        end else if (tick) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // An acknowledge on the final permitted cycle wins over the timeout.
    assign timeout = tick && !ack && (cnt_q == LAST_WAIT);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes and a
// wait watchdog. Define PERF_CNT_EN to build the retired/stall counters.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEF,
    parameter logic [5:0]  HALT_OP  = HALT_OP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic        ctl_RegWrite,
    input  logic        ctl_MemRead,
    input  logic        ctl_MemWrite,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_re,
    output logic        dmem_we,
    output logic        reg_we,
    output logic        pc_we,
    output logic        halted,
    output logic        err,
    output logic [31:0] instr_cnt,
    output logic [31:0] stall_cnt
);

    state_e state_q, state_d;
    logic   imem_req_q, imem_req_d;
    logic   dmem_re_q, dmem_re_d;
    logic   dmem_we_q, dmem_we_d;
    logic   reg_we_q, reg_we_d;
    logic   pc_we_q, pc_we_d;
    logic   halted_q, halted_d;
    logic   err_q, err_d;

    logic   wait_state;
    logic   ack_sel;
    logic   timeout;

    assign wait_state = is_wait_state(state_q);
    assign ack_sel    = (state_q == S_FETCH) ? imem_ack : dmem_ack;

    instr_sequencer_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!wait_state),
        .tick    (wait_state),
        .ack     (ack_sel),
        .timeout (timeout)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack)     state_d = S_DECODE;
                else if (timeout) state_d = S_ERR;
            end
            S_DECODE: state_d = (opcode == HALT_OP) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (ctl_MemRead && ctl_MemWrite)      state_d = S_ERR;
                else if (ctl_MemRead || ctl_MemWrite) state_d = S_MEM;
                else                                  state_d = S_WB;
            end
            S_MEM: begin
                if (dmem_ack)     state_d = S_WB;
                else if (timeout) state_d = S_ERR;
            end
            S_WB:     state_d = run ? S_FETCH : S_IDLE;
            S_HALT:   state_d = S_HALT;
            S_ERR:    state_d = S_ERR;
        endcase

        // Strobes are registered from the next state so they align with it.
        imem_req_d = (state_d == S_FETCH);
        dmem_re_d  = (state_d == S_MEM) && ctl_MemRead;
        dmem_we_d  = (state_d == S_MEM) && ctl_MemWrite;
        pc_we_d    = (state_d == S_WB);
        reg_we_d   = (state_d == S_WB) && ctl_RegWrite;
        halted_d   = halted_q || (state_d == S_HALT);
        err_d      = err_q || (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            imem_req_q <= 1'b0;
            dmem_re_q  <= 1'b0;
            dmem_we_q  <= 1'b0;
            reg_we_q   <= 1'b0;
            pc_we_q    <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            imem_req_q <= imem_req_d;
            dmem_re_q  <= dmem_re_d;
            dmem_we_q  <= dmem_we_d;
            reg_we_q   <= reg_we_d;
            pc_we_q    <= pc_we_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
        end
    end

    assign imem_req = imem_req_q;
    assign ir_we    = (state_q == S_FETCH) && imem_ack;
    assign dmem_re  = dmem_re_q;
    assign dmem_we  = dmem_we_q;
    assign reg_we   = reg_we_q;
    assign pc_we    = pc_we_q;
    assign halted   = halted_q;
    assign err      = err_q;

`ifdef PERF_CNT_EN
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall;

    assign stall = wait_state && !ack_sel;

    always_comb begin
        instr_cnt_d = instr_cnt_q + {31'd0, (state_q == S_WB)};
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign instr_cnt = instr_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign instr_cnt = 32'd0;
    assign stall_cnt = 32'd0;
`endif

endmodule
